// File: rtl/vram_pkg.sv
// Shared types and widths for the VRAM bridge: Avalon address/data widths,
// the bridge FSM state encoding and the write-FIFO entry layout.
`timescale 1ns/1ps
package vram_pkg;

    localparam int VRAM_AW = 16;
    localparam int VRAM_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR    = 2'd1,
        ST_RD    = 2'd2,
        ST_RWAIT = 2'd3
    } state_t;

    typedef struct packed {
        logic [VRAM_AW-1:0] addr;
        logic [VRAM_DW-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/vram_wfifo.sv
// Write-request FIFO: power-of-two depth, pointers one bit wider than the index
// so full/empty come straight from the pointer MSB difference.
`timescale 1ns/1ps
module vram_wfifo
    import vram_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_push,
    input  wr_entry_t               i_entry,
    input  logic                    i_pop,
    output logic                    o_full,
    output logic                    o_empty,
    output wr_entry_t               o_head,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int PW = $clog2(DEPTH);

    wr_entry_t   r_mem [DEPTH];
    logic [PW:0] r_wptr;
    logic [PW:0] r_rptr;
    logic        w_do_push;
    logic        w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // NOTE: registered state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // NOTE: storage is left unreset; the pointers alone decide which slots are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[PW-1:0]] <= i_entry;
    end

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign o_head  = r_mem[r_rptr[PW-1:0]];
    assign o_count = r_wptr - r_rptr;

endmodule

// File: rtl/vram_bridge.sv
// Bridges a simple write-posted / single-outstanding-read port onto an Avalon-MM
// SDRAM master. Queued writes always drain ahead of a read accepted after them.
`timescale 1ns/1ps
module vram_bridge
    import vram_pkg::*;
#(
    parameter int WDEPTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               write,
    input  logic [VRAM_AW-1:0] writeaddr,
    input  logic [VRAM_DW-1:0] writedata,
    output logic               wr_full,
    input  logic               read,
    input  logic [VRAM_AW-1:0] readaddr,
    output logic [VRAM_DW-1:0] readdata,
    output logic               rd_empty,
    output logic [VRAM_AW-1:0] avm_address,
    output logic               avm_write,
    output logic               avm_read,
    output logic [VRAM_DW-1:0] avm_writedata,
    input  logic [VRAM_DW-1:0] avm_readdata,
    input  logic               avm_waitrequest,
    input  logic               avm_readdatavalid
);

    localparam int CW = $clog2(WDEPTH) + 1;

    state_t             r_state;
    state_t             w_next;
    logic               r_rd_pending;
    logic [VRAM_AW-1:0] r_rd_addr;
    logic [CW-1:0]      r_wr_barrier;
    logic [VRAM_DW-1:0] r_readdata;
    logic               r_rd_empty;

    logic               w_push;
    logic               w_pop;
    logic               w_rd_accept;
    logic               w_rd_done;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [CW-1:0]      w_fifo_count;
    logic               w_wr_more;
    logic               w_barrier_clear;
    wr_entry_t          w_entry;
    wr_entry_t          w_head;

    assign w_entry     = '{addr: writeaddr, data: writedata};
    assign w_push      = write && !w_fifo_full;
    assign w_pop       = (r_state == ST_WR) && !avm_waitrequest;
    assign w_rd_accept = read && !r_rd_pending;
    assign w_rd_done   = (r_state == ST_RWAIT) && avm_readdatavalid;
    assign w_wr_more   = (w_fifo_count > CW'(1)) || w_push;
    // Barrier = writes queued ahead of the pending read; zero means the read may go.
    assign w_barrier_clear = r_rd_pending && (r_wr_barrier == '0);

    vram_wfifo #(
        .DEPTH (WDEPTH)
    ) u_wfifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_head),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // NOTE: w_next gets a default before the case so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty && !w_barrier_clear) w_next = ST_WR;
                else if (r_rd_pending)                 w_next = ST_RD;
            end
            ST_WR: begin
                if (w_pop) begin
                    if (r_rd_pending && (r_wr_barrier == CW'(1))) w_next = ST_IDLE;
                    else if (w_wr_more)                           w_next = ST_WR;
                    else                                          w_next = ST_IDLE;
                end
            end
            ST_RD: begin
                if (!avm_waitrequest) w_next = ST_RWAIT;
            end
            ST_RWAIT: begin
                if (avm_readdatavalid) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        avm_write     = 1'b0;
        avm_read      = 1'b0;
        avm_address   = '0;
        avm_writedata = '0;
        case (r_state)
            ST_WR: begin
                avm_write     = 1'b1;
                avm_address   = w_head.addr;
                avm_writedata = w_head.data;
            end
            ST_RD: begin
                avm_read    = 1'b1;
                avm_address = r_rd_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pending <= 1'b0;
            r_rd_addr    <= '0;
            r_wr_barrier <= '0;
            r_rd_empty   <= 1'b1;
            r_readdata   <= '0;
        end else begin
            if (w_rd_accept) begin
                r_rd_pending <= 1'b1;
                r_rd_addr    <= readaddr;
                r_rd_empty   <= 1'b1;
                r_wr_barrier <= w_fifo_count + CW'(w_push) - CW'(w_pop);
            end else if (w_pop && r_rd_pending && (r_wr_barrier != '0)) begin
                r_wr_barrier <= r_wr_barrier - 1'b1;
            end
            if (w_rd_done) begin
                r_rd_pending <= 1'b0;
                r_rd_empty   <= 1'b0;
                r_readdata   <= avm_readdata;
            end
        end
    end

    assign wr_full  = w_fifo_full;
    assign rd_empty = r_rd_empty;
    assign readdata = r_readdata;

endmodule
